// File: rtl/dtc_dadd_accum.sv
// dtc_dadd_accum
// ----------------------------------------------------------------------------
// Per-address accumulator fed by the DTC local agent write-beat stream.
// Each beat is address-checked, buffered in a small FIFO and added into one
// of DEPTH saturating 32-bit accumulators. Software reads accumulators through
// a read-and-clear port. A flush drains the FIFO and zeroes the whole bank.
// The input side has no backpressure: beats that cannot be buffered are
// dropped and counted.
//
// Ports:
//   clk           sole clock, posedge
//   reset_n       asynchronous active-low reset
//   dadd_in_en    beat valid (one beat per cycle)
//   dadd_in_addr  target byte address of the beat
//   dadd_in       unsigned addend
//   rd_req        read-and-clear request pulse
//   rd_idx        accumulator index to read
//   rd_vld        rd_data valid, one-cycle pulse
//   rd_data       accumulator value captured by the read
//   flush         start drain-and-clear
//   flush_busy    flush in progress
//   flush_done    one-cycle flush completion pulse
//   fifo_level    current FIFO occupancy
//   ovf_err       sticky: a beat was dropped
//   sat_err       sticky: an accumulator saturated
//   drop_cnt      saturating count of dropped beats
//   addr_err_cnt  saturating count of bad-address beats
//   err_clr       clears ovf_err, sat_err, drop_cnt, addr_err_cnt
// ----------------------------------------------------------------------------
module dtc_dadd_accum #(
    parameter int          DEPTH      = 16,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    localparam int         IW         = $clog2(DEPTH),
    localparam int         FW         = $clog2(FIFO_DEPTH),
    localparam int         LW         = FW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          dadd_in_en,
    input  logic [31:0]   dadd_in_addr,
    input  logic [31:0]   dadd_in,
    input  logic          rd_req,
    input  logic [IW-1:0] rd_idx,
    output logic          rd_vld,
    output logic [31:0]   rd_data,
    input  logic          flush,
    output logic          flush_busy,
    output logic          flush_done,
    output logic [LW-1:0] fifo_level,
    output logic          ovf_err,
    output logic          sat_err,
    output logic [15:0]   drop_cnt,
    output logic [15:0]   addr_err_cnt,
    input  logic          err_clr
);

    localparam int          EW   = IW + 32;
    localparam logic [32:0] SPAN = 33'(4 * DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    // Saturating 16-bit increment for the error counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // ---------------------------------------------------------------- state
    state_t            state_r;
    state_t            state_nxt_s;
    logic [EW-1:0]     fifo_mem_r [FIFO_DEPTH];
    logic [FW-1:0]     wr_ptr_r;
    logic [FW-1:0]     rd_ptr_r;
    logic [LW-1:0]     count_r;
    logic [31:0]       acc_r [DEPTH];
    logic [IW-1:0]     clr_idx_r;

    logic              rd_vld_r;
    logic [31:0]       rd_data_r;
    logic              busy_r;
    logic              done_r;
    logic              ovf_err_r;
    logic              sat_err_r;
    logic [15:0]       drop_cnt_r;
    logic [15:0]       addr_err_cnt_r;

    // ------------------------------------------------------------- datapath
    logic [32:0]       off_s;
    logic              addr_ok_s;
    logic [IW-1:0]     beat_idx_s;
    logic              push_req_s;
    logic              push_s;
    logic              drop_s;
    logic              addr_bad_s;
    logic              full_s;
    logic              pop_s;
    logic              rd_acc_s;
    logic              done_s;
    logic [IW-1:0]     head_idx_s;
    logic [31:0]       head_data_s;
    logic [32:0]       sum_s;
    logic              acc_we_s;
    logic [IW-1:0]     acc_wi_s;
    logic [31:0]       acc_wd_s;
    logic              sat_s;

    // Address decode: word-aligned and inside the accumulator window.
    // The subtraction is done in 33 bits so an address below BASE_ADDR shows
    // up as a borrow instead of wrapping into the window.
    always_comb begin
        off_s      = {1'b0, dadd_in_addr} - {1'b0, BASE_ADDR};
        addr_ok_s  = (dadd_in_addr[1:0] == 2'b00) && !off_s[32] && (off_s < SPAN);
        beat_idx_s = off_s[IW+1:2];
        full_s     = (count_r == LW'(FIFO_DEPTH));
        push_req_s = dadd_in_en && addr_ok_s;
        addr_bad_s = dadd_in_en && !addr_ok_s;
        // Fullness is judged on the registered count: a same-cycle pop
        // does not make room for the incoming beat.
        push_s     = push_req_s && !full_s && !busy_r;
        drop_s     = push_req_s && (full_s || busy_r);
    end

    // FIFO head and its 33-bit sum against the target accumulator.
    always_comb begin
        head_idx_s  = fifo_mem_r[rd_ptr_r][EW-1:32];
        head_data_s = fifo_mem_r[rd_ptr_r][31:0];
        sum_s       = {1'b0, acc_r[head_idx_s]} + {1'b0, head_data_s};
    end

    // FSM next-state, pop and read-accept decisions.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        rd_acc_s    = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                rd_acc_s = rd_req;
                if (flush) begin
                    // Nothing buffered and nothing arriving: skip DRAIN.
                    if ((count_r == LW'(0)) && !push_s) begin
                        state_nxt_s = ST_CLEAR;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end else if (push_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                rd_acc_s = rd_req;
                if (flush) begin
                    // The flush edge itself does not pop; DRAIN pops all.
                    if ((count_r == LW'(0)) && !push_s) begin
                        state_nxt_s = ST_CLEAR;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end else begin
                    // A read takes the accumulator port, so it stalls the pop.
                    if (!rd_req && (count_r != LW'(0))) begin
                        pop_s = 1'b1;
                    end else begin
                        pop_s = 1'b0;
                    end
                    if (!push_s && ((count_r == LW'(0)) ||
                                    (pop_s && (count_r == LW'(1))))) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
            end
            ST_DRAIN: begin
                if (count_r != LW'(0)) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
                if (count_r <= LW'(1)) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_CLEAR: begin
                if (clr_idx_r == IW'(DEPTH - 1)) begin
                    done_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Single accumulator write port: bank clear, read-clear, or accumulate.
    always_comb begin
        acc_we_s = 1'b0;
        acc_wi_s = '0;
        acc_wd_s = 32'd0;
        sat_s    = 1'b0;
        if (state_r == ST_CLEAR) begin
            acc_we_s = 1'b1;
            acc_wi_s = clr_idx_r;
        end else if (rd_acc_s) begin
            acc_we_s = 1'b1;
            acc_wi_s = rd_idx;
        end else if (pop_s) begin
            acc_we_s = 1'b1;
            acc_wi_s = head_idx_s;
            sat_s    = sum_s[32];
            if (sum_s[32]) begin
                acc_wd_s = 32'hFFFF_FFFF;
            end else begin
                acc_wd_s = sum_s[31:0];
            end
        end else begin
            acc_we_s = 1'b0;
        end
    end

    // FSM state register and clear-index counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            clr_idx_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_CLEAR) begin
                clr_idx_r <= clr_idx_r + IW'(1);
            end else begin
                clr_idx_r <= '0;
            end
        end
    end

    // Input FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {beat_idx_s, dadd_in};
                wr_ptr_r             <= wr_ptr_r + FW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + FW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + LW'(1);
                2'b01:   count_r <= count_r - LW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Accumulator bank.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                acc_r[i] <= 32'd0;
            end
        end else if (acc_we_s) begin
            acc_r[acc_wi_s] <= acc_wd_s;
        end
    end

    // Read port and flush status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_r  <= 1'b0;
            rd_data_r <= 32'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            rd_vld_r <= rd_acc_s;
            if (rd_acc_s) begin
                rd_data_r <= acc_r[rd_idx];
            end
            busy_r <= (state_nxt_s == ST_DRAIN) || (state_nxt_s == ST_CLEAR);
            done_r <= done_s;
        end
    end

    // Sticky error flags and saturating error counters; err_clr wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_err_r      <= 1'b0;
            sat_err_r      <= 1'b0;
            drop_cnt_r     <= 16'd0;
            addr_err_cnt_r <= 16'd0;
        end else if (err_clr) begin
            ovf_err_r      <= 1'b0;
            sat_err_r      <= 1'b0;
            drop_cnt_r     <= 16'd0;
            addr_err_cnt_r <= 16'd0;
        end else begin
            if (drop_s) begin
                ovf_err_r  <= 1'b1;
                drop_cnt_r <= sat_inc16(drop_cnt_r);
            end
            if (addr_bad_s) begin
                addr_err_cnt_r <= sat_inc16(addr_err_cnt_r);
            end
            if (sat_s) begin
                sat_err_r <= 1'b1;
            end
        end
    end

    assign rd_vld       = rd_vld_r;
    assign rd_data      = rd_data_r;
    assign flush_busy   = busy_r;
    assign flush_done   = done_r;
    assign fifo_level   = count_r;
    assign ovf_err      = ovf_err_r;
    assign sat_err      = sat_err_r;
    assign drop_cnt     = drop_cnt_r;
    assign addr_err_cnt = addr_err_cnt_r;

endmodule

// File: doc/dtc_dadd_accum.md
# dtc_dadd_accum

Per-address accumulator that consumes the `dadd_in_en` / `dadd_in_addr` / `dadd_in` write-beat stream driven by the DTC local agent. Each beat is address-checked, buffered in a small FIFO and added into one of `DEPTH` saturating 32-bit accumulators. Software reads accumulators back through a read-and-clear port. A flush sequence drains the FIFO and zeroes the bank. The input side has no backpressure, so overflow is handled by dropping and counting beats.

## Interface
Parameters:
- `DEPTH`, 16: number of accumulators, power of two; `IW = $clog2(DEPTH)`.
- `FIFO_DEPTH`, 8: input buffer entries, power of two.
- `BASE_ADDR`, 32'h0000_1000: address of accumulator 0; word stride 4.

Ports:
- `clk`  in  1: sole clock, all logic on posedge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `dadd_in_en`  in  1: beat valid, one beat per cycle.
- `dadd_in_addr`  in  32: target byte address.
- `dadd_in`  in  32: unsigned addend.
- `rd_req`  in  1: read-and-clear request pulse.
- `rd_idx`  in  IW: accumulator index to read.
- `rd_vld`  out  1: `rd_data` valid, one-cycle pulse.
- `rd_data`  out  32: accumulator value.
- `flush`  in  1: start drain-and-clear.
- `flush_busy`  out  1: flush in progress.
- `flush_done`  out  1: one-cycle completion pulse.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `ovf_err`  out  1: sticky, a beat was dropped.
- `sat_err`  out  1: sticky, an accumulator saturated.
- `drop_cnt`  out  16: saturating count of dropped beats.
- `addr_err_cnt`  out  16: saturating count of bad-address beats.
- `err_clr`  in  1: clears `ovf_err`, `sat_err`, `drop_cnt` and `addr_err_cnt`.

## Operation
- **Reset:** all outputs 0; accumulators 0; FIFO empty; FSM in IDLE.
- **Address check at input:** a beat is valid only if `addr[1:0]==0` and `BASE_ADDR <= addr < BASE_ADDR+4*DEPTH`.
  - Invalid beat: discarded, `addr_err_cnt`++, never enters the FIFO.
  - Index of a valid beat = `(addr-BASE_ADDR)>>2`.
- **Push:** a valid beat is pushed as {index, data}.
  - If the FIFO is full (registered count) it is dropped, even if a pop occurs in the same cycle.
  - If `flush_busy`=1 it is dropped.
  - A drop sets `ovf_err` and increments `drop_cnt`.
- **Addition:** 33-bit sum of the accumulator and the data. If bit 32 is set, store 32'hFFFF_FFFF and set `sat_err`.
- **FSM states:** IDLE, RUN, DRAIN, CLEAR.
  - IDLE: FIFO empty. Goes to RUN when the FIFO becomes non-empty. Goes to DRAIN on `flush`.
  - RUN: pops one entry per cycle and accumulates it. If a `rd_req` is present, that cycle's pop is stalled (read has priority). Returns to IDLE when the last entry is popped and no push occurs in the same cycle. Goes to DRAIN on `flush`.
  - DRAIN: `flush_busy`=1. Pops until the FIFO is empty; `rd_req` is ignored. Then goes to CLEAR.
  - CLEAR: zeroes one accumulator per cycle, indices 0..DEPTH-1 (DEPTH cycles). On the last index, pulses `flush_done` and returns to IDLE. `flush_busy` drops in the same cycle `flush_done` pulses.
- **Read:** accepted in IDLE or RUN. `rd_data` = the accumulator value including every pop committed on earlier edges. The entry is cleared on the same edge that captures `rd_data`.
- **Flush handling:** `flush` while `flush_busy`=1 is ignored.
- **Error clear:** `err_clr` has priority over a same-cycle increment; the counters end at 0.

## Timing
- **Input latency:** beat at edge N → FIFO head at N+1 → pop at edge N+1 → a `rd_req` from cycle N+2 observes it. Minimum latency is 2 cycles.
- **Read latency:** `rd_req` sampled at edge M → `rd_vld`=1 and `rd_data` stable during cycle M+1.
  - Back-to-back `rd_req` gives consecutive `rd_vld` cycles.
  - Each read stalls one pop.
- **Throughput:** one beat per cycle sustained while no reads occur; the FIFO never grows.
- **Flush duration:** `flush` at edge F with the FIFO holding k entries → `flush_done` at edge F+k+DEPTH (k=0 → F+DEPTH).
- **Reset mid-operation:** async reset discards FIFO contents and the in-flight flush immediately. No `rd_vld` or `flush_done` is emitted after reset asserts.

## Test plan
- **Single beat:** 3 beats of 0x10 to 0x1004 → `rd_req` idx 1 two cycles after the last beat → `rd_vld` with `rd_data`=0x30. A second read returns 0.
- **Bad addresses:** beats to 0x1002, 0x0FFC and 0x1040 → `addr_err_cnt`=3, all accumulators unchanged, `fifo_level` stays 0.
- **Overflow:** hold `rd_req` high for 12 cycles while 12 valid beats stream in → 8 buffered, 4 dropped, `drop_cnt`=4, `ovf_err`=1. After release, the FIFO drains in 8 cycles. `err_clr` → counters 0.
- **Saturation:** add 0xFFFF_FFF0 then 0x20 to idx 0 → read 0xFFFF_FFFF, `sat_err`=1.
- **Flush:** with 5 entries queued, pulse `flush` → `flush_busy` for 5+16 cycles; `flush_done` at edge F+21; beats during the flush counted as drops; every read afterwards returns 0.
- **Reset mid-flush:** assert `reset_n`=0 during CLEAR → all outputs 0 and `flush_done` never pulses. After release, normal accumulation resumes.
